wb_arbiter: RTL

//  Write-back arbiter in front of the regfile's single write port (we/waddr/wdata).

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the pipeline owns the regfile write port, and long-latency results queue in a FIFO that drains into idle cycles.
// Optional pending-register scoreboard is enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          lu_valid,
    input  logic [AW-1:0] lu_waddr,
    input  logic [DW-1:0] lu_wdata,
    output logic          lu_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] chk_addr1,
    input  logic [AW-1:0] chk_addr2,
    output logic          busy1,
    output logic          busy2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic pipe_req;
    logic accept;
    logic push;
    logic push_vld;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // lu handshake: a result transfers on any posedge where lu_valid && lu_ready;
    // lu_ready depends only on registered count, never on lu_valid.
    assign lu_ready = (count < DEPTH_C);
    assign accept   = lu_valid && lu_ready;
    assign push     = accept && (lu_waddr != '0);
    assign pipe_req = pipe_we && (pipe_waddr != '0);
    assign pop      = !pipe_req && (count != '0);
    // A same-cycle pipeline write to the same register is younger, so the incoming entry is born dead.
    assign push_vld = !(pipe_req && (pipe_waddr == lu_waddr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (pipe_req) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_addr[i] == pipe_waddr) q_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= ptr_inc(head);
            end
            if (push) begin
                q_addr[tail] <= lu_waddr;
                q_data[tail] <= lu_wdata;
                q_vld[tail]  <= push_vld;
                tail         <= ptr_inc(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (pipe_req) begin
            we    <= 1'b1;
            waddr <= pipe_waddr;
            wdata <= pipe_wdata;
        end else if (pop) begin
            we    <= q_vld[head];
            waddr <= q_addr[head];
            wdata <= q_data[head];
        end else begin
            we    <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        busy1 = accept && (lu_waddr == chk_addr1);
        busy2 = accept && (lu_waddr == chk_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == chk_addr1)) busy1 = 1'b1;
            if (q_vld[i] && (q_addr[i] == chk_addr2)) busy2 = 1'b1;
        end
        if (chk_addr1 == '0) busy1 = 1'b0;
        if (chk_addr2 == '0) busy2 = 1'b0;
    end
`else
    logic unused_chk;
    assign unused_chk = ^{chk_addr1, chk_addr2};
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif

endmodule
